// File: rtl/ssd1322_pkg.sv
// Shared SSD1322 bus definitions: opcodes, receiver FSM states and the
// command arity table used by both the receiver and the transmitter.
package ssd1322_pkg;

  localparam logic [7:0] CMD_SET_COL   = 8'h15;
  localparam logic [7:0] CMD_SET_ROW   = 8'h75;
  localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;
  localparam logic [7:0] CMD_REMAP     = 8'hA0;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0] CMD_CLK_DIV   = 8'hB3;
  localparam logic [7:0] CMD_SET_VSL   = 8'hB4;
  localparam logic [7:0] CMD_DISP_ENH  = 8'hD1;

  localparam logic [6:0] RESET_COL_END = 7'h77;
  localparam logic [6:0] RESET_ROW_END = 7'h7F;

  // Arity code 3 marks a command followed by an unbounded data stream.
  localparam logic [1:0] ARITY_UNBOUNDED = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_WRITE_RAM
  } rx_state_t;

  function automatic logic [1:0] cmd_arity(input logic [7:0] c);
    case (c)
      CMD_SET_COL, CMD_SET_ROW, CMD_REMAP,
      CMD_SET_VSL, CMD_DISP_ENH:       return 2'd2;
      CMD_DISP_OFF, CMD_DISP_ON:       return 2'd0;
      CMD_WRITE_RAM:                   return ARITY_UNBOUNDED;
      default:                         return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/ssd1322_addr_gen.sv
// Column/row write window, RAM pointers and framebuffer address formation
// for bytes streamed after Write RAM.
module ssd1322_addr_gen
  import ssd1322_pkg::*;
#(
  parameter int COL_OFFSET = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        col_start_we,
  input  logic        col_end_we,
  input  logic        row_start_we,
  input  logic        row_end_we,
  input  logic [6:0]  value,
  input  logic        write_start,
  input  logic        ram_byte,
  input  logic [7:0]  ram_data,
  output logic        pixel_we,
  output logic [12:0] pixel_addr,
  output logic [7:0]  pixel_data
);

  localparam logic [6:0] COL_FIRST = 7'(COL_OFFSET);
  localparam logic [7:0] COL_LAST  = 8'(COL_OFFSET + 63);

  logic [6:0] col_start_reg, col_end_reg, row_start_reg, row_end_reg;
  logic [6:0] col_reg, row_reg;
  logic       byte_sel_reg;
  logic [5:0] col_off;
  logic       in_range;
  logic [6:0] row_adv;

  assign col_off  = 6'(col_reg - COL_FIRST);
  assign in_range = (col_reg >= COL_FIRST) && ({1'b0, col_reg} <= COL_LAST) &&
                    (row_reg < 7'd64);
  // Pointers wrap mod 128, so a start>end window still reaches its end.
  assign row_adv  = (row_reg == row_end_reg) ? row_start_reg : row_reg + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_start_reg <= 7'h00;
      col_end_reg   <= RESET_COL_END;
      row_start_reg <= 7'h00;
      row_end_reg   <= RESET_ROW_END;
      col_reg       <= 7'h00;
      row_reg       <= 7'h00;
      byte_sel_reg  <= 1'b0;
      pixel_we      <= 1'b0;
      pixel_addr    <= '0;
      pixel_data    <= '0;
    end else begin
      pixel_we <= 1'b0;
      if (col_start_we) begin
        col_start_reg <= value;
        col_reg       <= value;
      end
      if (col_end_we) col_end_reg <= value;
      if (row_start_we) begin
        row_start_reg <= value;
        row_reg       <= value;
      end
      if (row_end_we) row_end_reg <= value;
      if (write_start) byte_sel_reg <= 1'b0;
      if (ram_byte) begin
        pixel_we     <= in_range;
        pixel_addr   <= {row_reg[5:0], col_off, byte_sel_reg};
        pixel_data   <= ram_data;
        byte_sel_reg <= ~byte_sel_reg;
        if (byte_sel_reg) begin
          if (col_reg == col_end_reg) begin
            col_reg <= col_start_reg;
            row_reg <= row_adv;
          end else begin
            col_reg <= col_reg + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ssd1322_rx.sv
// SSD1322 parallel-bus responder: synchronizes the bus, detects E falling
// edges, decodes commands/parameters and drives framebuffer write strobes.
module ssd1322_rx
  import ssd1322_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COL_OFFSET  = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        oled_cs,
  input  logic        oled_dc,
  input  logic        oled_e,
  input  logic [7:0]  oled_din,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        param_valid,
  output logic [7:0]  param,
  output logic        param_idx,
  output logic        pixel_we,
  output logic [12:0] pixel_addr,
  output logic [7:0]  pixel_data,
  output logic        display_on,
  output logic        err_stray
);

  logic [SYNC_STAGES-1:0]      cs_sync, dc_sync, e_sync;
  logic [SYNC_STAGES-1:0][7:0] din_sync;
  logic                        e_last;
  logic                        cs_s, dc_s, e_s;
  logic [7:0]                  din_s;
  logic                        byte_ev;

  rx_state_t  state_reg, state_next;
  logic       pidx_reg, pidx_next;
  logic [1:0] arity_reg, arity_next;

  logic is_cmd, is_param, is_stray, is_ram;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      dc_sync  <= '0;
      e_sync   <= '0;
      din_sync <= '0;
      e_last   <= 1'b0;
    end else begin
      cs_sync[0]  <= oled_cs;
      dc_sync[0]  <= oled_dc;
      e_sync[0]   <= oled_e;
      din_sync[0] <= oled_din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]  <= cs_sync[i-1];
        dc_sync[i]  <= dc_sync[i-1];
        e_sync[i]   <= e_sync[i-1];
        din_sync[i] <= din_sync[i-1];
      end
      e_last <= e_s;
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign dc_s    = dc_sync[SYNC_STAGES-1];
  assign e_s     = e_sync[SYNC_STAGES-1];
  assign din_s   = din_sync[SYNC_STAGES-1];
  assign byte_ev = e_last && !e_s && !cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pidx_reg  <= 1'b0;
      arity_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      pidx_reg  <= pidx_next;
      arity_reg <= arity_next;
    end
  end

  // A command byte is accepted in any state and restarts decoding.
  always_comb begin
    state_next = state_reg;
    pidx_next  = pidx_reg;
    arity_next = arity_reg;
    if (byte_ev && !dc_s) begin
      arity_next = cmd_arity(din_s);
      pidx_next  = 1'b0;
      if (arity_next == 2'd0)                 state_next = ST_IDLE;
      else if (arity_next == ARITY_UNBOUNDED) state_next = ST_WRITE_RAM;
      else                                    state_next = ST_PARAM;
    end else if (byte_ev && dc_s && state_reg == ST_PARAM) begin
      pidx_next = pidx_reg + 1'b1;
      if ({1'b0, pidx_reg} + 2'd1 == arity_reg) state_next = ST_IDLE;
    end
  end

  always_comb begin
    is_cmd   = byte_ev && !dc_s;
    is_param = byte_ev && dc_s && (state_reg == ST_PARAM);
    is_stray = byte_ev && dc_s && (state_reg == ST_IDLE);
    is_ram   = byte_ev && dc_s && (state_reg == ST_WRITE_RAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd         <= 8'h00;
      param_valid <= 1'b0;
      param       <= 8'h00;
      param_idx   <= 1'b0;
      err_stray   <= 1'b0;
      display_on  <= 1'b0;
    end else begin
      cmd_valid   <= is_cmd;
      param_valid <= is_param;
      err_stray   <= is_stray;
      if (is_cmd) begin
        cmd <= din_s;
        if (din_s == CMD_DISP_ON)  display_on <= 1'b1;
        if (din_s == CMD_DISP_OFF) display_on <= 1'b0;
      end
      if (is_param) begin
        param     <= din_s;
        param_idx <= pidx_reg;
      end
    end
  end

  ssd1322_addr_gen #(
    .COL_OFFSET(COL_OFFSET)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_start_we (is_param && cmd == CMD_SET_COL && !pidx_reg),
    .col_end_we   (is_param && cmd == CMD_SET_COL &&  pidx_reg),
    .row_start_we (is_param && cmd == CMD_SET_ROW && !pidx_reg),
    .row_end_we   (is_param && cmd == CMD_SET_ROW &&  pidx_reg),
    .value        (din_s[6:0]),
    .write_start  (is_cmd && din_s == CMD_WRITE_RAM),
    .ram_byte     (is_ram),
    .ram_data     (din_s),
    .pixel_we     (pixel_we),
    .pixel_addr   (pixel_addr),
    .pixel_data   (pixel_data)
  );

endmodule
